rom_stream_loader: RTL
======================

Name: rom_stream_loader

Overview:
Writer-side counterpart of the team's 256x8 readmem-style ROM: fills the same memory at run time from a byte stream instead of from a file. A valid/ready stream is written to auto-incrementing addresses from a programmable base, and an erase sequence zero-fills the whole array. The block also exposes the existing read-port contract (address/read_en/ce/data), so it drops in where the file-loaded ROM sits. It sits between a host/DMA byte source and the consumer of the lookup memory.

Parameters:
DATA_WIDTH, 8, width of each memory word and of in_data/data
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH (256)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a LOAD at base_addr (sampled in IDLE only)
erase  input  1  pulse; begins an ERASE of all DEPTH words (sampled in IDLE only)
base_addr  input  ADDR_WIDTH  first write address of a LOAD, sampled with start
in_valid  input  1  stream data valid
in_data  input  DATA_WIDTH  stream byte
in_last  input  1  marks final byte of a load
in_ready  output  1  block accepts a byte this cycle
busy  output  1  high in LOAD or ERASE
done  output  1  one-cycle pulse at end of LOAD or ERASE
count  output  ADDR_WIDTH+1  bytes written in current/last LOAD
overflow  output  1  sticky: LOAD hit DEPTH bytes without in_last
address  input  ADDR_WIDTH  read address
read_en  input  1  read enable
ce  input  1  chip enable
data  output  DATA_WIDTH  read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. Reset drives state=IDLE, in_ready=0, busy=0, done=0, count=0, overflow=0, write pointer=0. Memory contents are NOT reset.
- Reset mid-LOAD/ERASE: abort immediately. Words already written stay written. No done pulse.
- States: IDLE, LOAD, ERASE, DONE (registered).
- IDLE:
  - erase=1 -> ERASE, ptr=0, overflow=0.
  - else start=1 -> LOAD, ptr=base_addr, count=0, overflow=0.
  - erase and start in the same cycle: erase wins, start is dropped.
  - start/erase outside IDLE: ignored.
- LOAD:
  - in_ready=1, decoded from the state register, so it is first high the cycle after start is accepted.
  - Each handshake (in_valid && in_ready) writes mem[ptr]=in_data at the edge, then ptr+1 (wraps modulo DEPTH) and count+1.
  - Handshake with in_last=1 -> DONE.
  - Handshake that makes count==DEPTH with in_last=0 -> overflow=1, DONE. No further bytes accepted.
  - in_valid=0: hold; no timeout.
- ERASE:
  - Writes mem[ptr]=0 each cycle, ptr 0..DEPTH-1.
  - After writing DEPTH-1 -> DONE, so busy is high for exactly DEPTH cycles.
  - in_ready=0 throughout. count is unchanged.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- count and overflow hold their values until the next accepted start/erase.
- Read port (combinational): data = (ce && read_en) ? mem[address] : 0.
  - A write becomes visible on data from the cycle after its edge.
  - Same-address read during the write cycle returns the old value.
  - Reads are legal in every state, including mid-LOAD/ERASE.
- Width rules: ptr is ADDR_WIDTH bits, wrapping naturally. count is ADDR_WIDTH+1 bits so the value DEPTH is representable.

Decomposition:
- Package rom_stream_loader_pkg: state enum (IDLE/LOAD/ERASE/DONE), DEPTH derivation function, erase fill constant (all zeros).
- One sub-module, rom_mem_array: DEPTH x DATA_WIDTH storage with one synchronous write port (we, waddr, wdata) and the combinational ce/read_en gated read mux.
- The FSM, pointer and counter stay in the top.

Test Plan:
- Erase: pulse erase, then read addresses 0, 128, 255 with ce=read_en=1 -> data=8'h00; busy high exactly 256 cycles; done pulses once.
- Load with wrap: start with base_addr=8'hFE, stream 8'hA1, 8'hB2, 8'hC3 (in_last on C3) -> mem[FE]=A1, mem[FF]=B2, mem[00]=C3; count=3; overflow=0.
- Backpressure gaps: toggle in_valid 1-0-0-1 across a 4-byte load -> exactly 4 writes, count=4, no duplicates.
- Overflow: 256 bytes without in_last -> overflow=1 and done pulse after byte 256; in_ready low next cycle; byte 257 not written.
- Read gating: after loading mem[10]=8'h5A, read address 10 with ce=1/read_en=0, then ce=0/read_en=1, then both 1 -> data=00, 00, 5A.
- Reset and contention:
  - rst_n low after 2 bytes of a load at base 0 -> in_ready=0, count=0, mem[0..1] retained.
  - start+erase in the same cycle -> ERASE runs; start is ignored.

Source files
------------

// File: rtl/rom_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// rom_stream_loader_pkg
//   Shared types and constants for the run-time ROM loader.
//   - state_t        : controller states (IDLE / LOAD / ERASE / DONE)
//   - depth_of()     : number of words addressed by an address bus
//   - ERASE_FILL_BIT : bit value replicated across a word during ERASE
// -----------------------------------------------------------------------------
package rom_stream_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ERASE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

   localparam logic ERASE_FILL_BIT = 1'b0;

endpackage : rom_stream_loader_pkg

// File: rtl/rom_mem_array.sv
// -----------------------------------------------------------------------------
// rom_mem_array
//   DEPTH x DATA_WIDTH storage with one synchronous write port and a
//   combinational, gated read port matching the file-loaded ROM contract.
//   Ports:
//     clk             : write clock
//     we/waddr/wdata  : synchronous write port
//     address         : read address
//     read_en, ce     : both must be high to drive data, else data = 0
//     data            : read data (shows the pre-edge value during a write)
// -----------------------------------------------------------------------------
module rom_mem_array
   import rom_stream_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read_en,
   input  logic                  ce,
   output logic [DATA_WIDTH-1:0] data
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset branch on purpose; contents survive rst_n
   // and a reset port would force the storage into flops instead of RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign data = (ce && read_en) ? r_mem[address] : '0;

endmodule : rom_mem_array

// File: rtl/rom_stream_loader.sv
// -----------------------------------------------------------------------------
// rom_stream_loader
//   Fills a DEPTH-word memory at run time from a valid/ready byte stream
//   (auto-incrementing from base_addr) or zero-fills it with an ERASE pass,
//   and exposes the usual ROM read port.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     start, base_addr    : begin a LOAD at base_addr (accepted in IDLE only)
//     erase               : begin an ERASE of all words (wins over start)
//     in_valid/in_data/in_last/in_ready : byte stream, in_last ends a LOAD
//     busy, done          : activity flag, one-cycle completion pulse
//     count, overflow     : bytes written by the last LOAD, sticky overflow
//     address/read_en/ce/data : combinational read port
// -----------------------------------------------------------------------------
module rom_stream_loader
   import rom_stream_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  erase,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read_en,
   input  logic                  ce,
   output logic [DATA_WIDTH-1:0] data
);

   localparam int                DEPTH     = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;

   logic                  w_hs;
   logic [ADDR_WIDTH:0]   w_count_inc;
   logic                  w_full;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_wdata;

   // in_ready comes straight from the state register, so a handshake is only
   // possible from the cycle after start is accepted.
   assign w_hs        = (r_state == ST_LOAD) && in_valid;
   assign w_count_inc = r_count + 1'b1;
   // Without in_last, the DEPTH-th byte ends the load and raises overflow.
   assign w_full      = (w_count_inc == DEPTH_CNT);

   // NOTE: every always_comb output gets a default first so no path leaves a
   // signal unassigned, which would infer a latch.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (erase) begin
               w_state_next = ST_ERASE;
            end else if (start) begin
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_hs && (in_last || w_full)) begin
               w_state_next = ST_DONE;
            end
         end
         ST_ERASE: begin
            if (r_ptr == '1) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               // ERASE leaves count alone; LOAD restarts it.
               if (erase) begin
                  r_ptr      <= '0;
                  r_overflow <= 1'b0;
               end else if (start) begin
                  r_ptr      <= base_addr;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_hs) begin
                  r_ptr   <= r_ptr + 1'b1;
                  r_count <= w_count_inc;
                  if (!in_last && w_full) begin
                     r_overflow <= 1'b1;
                  end
               end
            end
            ST_ERASE: begin
               r_ptr <= r_ptr + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign w_we    = w_hs || (r_state == ST_ERASE);
   assign w_wdata = (r_state == ST_ERASE) ? {DATA_WIDTH{ERASE_FILL_BIT}} : in_data;

   rom_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .we      (w_we),
      .waddr   (r_ptr),
      .wdata   (w_wdata),
      .address (address),
      .read_en (read_en),
      .ce      (ce),
      .data    (data)
   );

   assign in_ready = (r_state == ST_LOAD);
   assign busy     = (r_state == ST_LOAD) || (r_state == ST_ERASE);
   assign done     = (r_state == ST_DONE);
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule : rom_stream_loader
